// File: rtl/m2s_desc_sched.sv
// Descriptor scheduler for the memory-to-stream read engine: queues (address, byte-count)
// descriptors and issues them to the engine as chunks that never cross a 4 KB boundary.
module m2s_desc_sched #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 64,
    parameter int WIDTH_LEN    = 16,
    parameter int DEPTH        = 4,
    parameter int MAX_CHUNK    = 256,
    parameter int TIMEOUT      = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      ENABLE,
    input  logic                      DESC_VALID,
    output logic                      DESC_READY,
    input  logic [AXI_WIDTH_AD-1:0]   DESC_ADDR,
    input  logic [WIDTH_LEN-1:0]      DESC_BNUM,
    input  logic                      FLUSH,
    output logic                      ENG_GO,
    output logic [AXI_WIDTH_AD-1:0]   ENG_ADDR,
    output logic [12:0]               ENG_BNUM,
    input  logic                      ENG_BUSY,
    input  logic                      ENG_DONE,
    output logic [$clog2(DEPTH):0]    PEND,
    output logic                      BUSY,
    output logic [15:0]               DONE_CNT,
    input  logic                      IRQ_EN,
    output logic                      IRQ,
    input  logic                      IRQ_CLR,
    output logic                      ERR,
    input  logic                      ERR_CLR
);

    localparam int AW = $clog2(AXI_WIDTH_DA / 8);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (WIDTH_LEN > 13) ? WIDTH_LEN + 1 : 14;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GO   = 3'd2,
        S_WAIT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Sub-beat address/length bits are meaningless to the engine and are dropped.
    function automatic logic [AXI_WIDTH_AD-1:0] align_addr(input logic [AXI_WIDTH_AD-1:0] a);
        return (a >> AW) << AW;
    endfunction

    function automatic logic [WIDTH_LEN-1:0] align_len(input logic [WIDTH_LEN-1:0] l);
        return (l >> AW) << AW;
    endfunction

    logic [AXI_WIDTH_AD-1:0] addr_mem_r [DEPTH];
    logic [WIDTH_LEN-1:0]    bnum_mem_r [DEPTH];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [PW:0]             count_r;

    state_t                  state_r;
    state_t                  state_nx;
    logic [AXI_WIDTH_AD-1:0] cur_addr_r;
    logic [WIDTH_LEN-1:0]    cur_rem_r;
    logic [AXI_WIDTH_AD-1:0] eng_addr_r;
    logic [12:0]             eng_bnum_r;
    logic                    eng_go_r;
    logic [TW-1:0]           tmo_r;
    logic                    busy_r;
    logic [15:0]             done_cnt_r;
    logic                    irq_r;
    logic                    err_r;

    logic                    push_s;
    logic                    pop_s;
    logic                    rem_zero_s;
    logic                    last_chunk_s;
    logic                    issue_s;
    logic                    complete_s;
    logic                    tmo_hit_s;
    logic [12:0]             bnd_s;
    logic [CW-1:0]           chunk_a_s;
    logic [CW-1:0]           chunk_s;

    assign DESC_READY = !ARESET && (count_r != (PW+1)'(DEPTH));
    assign push_s     = DESC_VALID && DESC_READY && !FLUSH;
    assign pop_s      = (state_r == S_IDLE) && ENABLE && (count_r != '0) && !FLUSH;

    // Chunk = min(remaining, MAX_CHUNK, bytes left in this 4 KB page); the page term is 1..4096.
    assign bnd_s     = 13'h1000 - {1'b0, cur_addr_r[11:0]};
    assign chunk_a_s = (CW'(cur_rem_r) < CW'(MAX_CHUNK)) ? CW'(cur_rem_r) : CW'(MAX_CHUNK);
    assign chunk_s   = (chunk_a_s < CW'(bnd_s)) ? chunk_a_s : CW'(bnd_s);

    assign rem_zero_s   = (cur_rem_r == '0);
    assign last_chunk_s = (CW'(cur_rem_r) == CW'(eng_bnum_r));
    assign issue_s      = ((state_r == S_LOAD) && !rem_zero_s && !ENG_BUSY) ||
                          ((state_r == S_GO) && !ENG_BUSY);
    assign complete_s   = ((state_r == S_LOAD) && rem_zero_s) ||
                          ((state_r == S_WAIT) && ENG_DONE && last_chunk_s);
    assign tmo_hit_s    = (state_r == S_WAIT) && !ENG_DONE && (tmo_r == TW'(TIMEOUT - 1));

    // Descriptor storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= DESC_ADDR;
            bnum_mem_r[wr_ptr_r] <= DESC_BNUM;
        end
    end

    // FIFO pointers and occupancy; a flush drops everything not yet popped.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (FLUSH) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state_r <= S_IDLE;
        else        state_r <= state_nx;
    end

    // Next-state decode; LOAD issues directly when the engine is already free.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (pop_s) state_nx = S_LOAD;
                else       state_nx = S_IDLE;
            end
            S_LOAD: begin
                if (rem_zero_s)     state_nx = S_IDLE;
                else if (!ENG_BUSY) state_nx = S_WAIT;
                else                state_nx = S_GO;
            end
            S_GO: begin
                if (!ENG_BUSY) state_nx = S_WAIT;
                else           state_nx = S_GO;
            end
            S_WAIT: begin
                if (ENG_DONE)       state_nx = last_chunk_s ? S_IDLE : S_LOAD;
                else if (tmo_hit_s) state_nx = S_ERR;
                else                state_nx = S_WAIT;
            end
            S_ERR: begin
                if (ERR_CLR) state_nx = S_IDLE;
                else         state_nx = S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath, engine command registers and status flags.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cur_addr_r <= '0;
            cur_rem_r  <= '0;
            eng_addr_r <= '0;
            eng_bnum_r <= '0;
            eng_go_r   <= 1'b0;
            tmo_r      <= '0;
            busy_r     <= 1'b0;
            done_cnt_r <= '0;
            irq_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                cur_addr_r <= align_addr(addr_mem_r[rd_ptr_r]);
                cur_rem_r  <= align_len(bnum_mem_r[rd_ptr_r]);
            end else if ((state_r == S_WAIT) && ENG_DONE) begin
                cur_addr_r <= cur_addr_r + AXI_WIDTH_AD'(eng_bnum_r);
                cur_rem_r  <= cur_rem_r - WIDTH_LEN'(eng_bnum_r);
            end
            if ((state_r == S_LOAD) && !rem_zero_s) begin
                eng_addr_r <= cur_addr_r;
                eng_bnum_r <= chunk_s[12:0];
            end
            eng_go_r <= issue_s;
            if (issue_s)
                tmo_r <= '0;
            else if ((state_r == S_WAIT) && !ENG_DONE)
                tmo_r <= tmo_r + TW'(1);
            busy_r <= (state_nx != S_IDLE);
            if (complete_s) done_cnt_r <= done_cnt_r + 16'd1;
            if (complete_s && IRQ_EN) irq_r <= 1'b1;
            else if (IRQ_CLR)         irq_r <= 1'b0;
            if (tmo_hit_s)    err_r <= 1'b1;
            else if (ERR_CLR) err_r <= 1'b0;
        end
    end

    assign ENG_GO   = eng_go_r;
    assign ENG_ADDR = eng_addr_r;
    assign ENG_BNUM = eng_bnum_r;
    assign PEND     = count_r;
    assign BUSY     = busy_r;
    assign DONE_CNT = done_cnt_r;
    assign IRQ      = irq_r;
    assign ERR      = err_r;

endmodule
